jk_target_driver: RTL

Drives the J/K inputs of an N-bit bank of negedge-clocked JK flip-flops so that the bank reaches a requested target word. Computes the JK excitation for each bit from the bank's current Q and applies it for one cycle. Checks the Q feedback and retries a bounded number of times. Reports done or error to the upstream controller. It is the excitation side of the lab's JK storage elements: it produces the J/K stimulus that the flip-flops consume.

---
 rtl/jk_pkg.sv | 25 ++
 rtl/jk_excite.sv | 24 ++
 rtl/jk_target_driver.sv | 113 +++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared encodings for the JK target driver: FSM states and {J,K} pair codes.
package jk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  // {J,K} excitation pairs.
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Excitation that moves one flip-flop from q to t on its next clock.
  function automatic logic [1:0] jk_pair(input logic q, input logic t,
                                         input logic use_toggle);
    if (q == t)          return JK_HOLD;
    else if (use_toggle) return JK_TOGGLE;
    else if (t)          return JK_SET;
    else                 return JK_RESET;
  endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational JK excitation for a WIDTH-bit bank: current Q -> target T.
module jk_excite
  import jk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] t,
  input  logic             use_toggle,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  // Per-bit excitation lookup; don't-care positions resolve to 0.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    j = '0;
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {j[i], k[i]} = jk_pair(q[i], t[i], use_toggle);
    end
  end

endmodule

// File: rtl/jk_target_driver.sv
// Drives a negedge JK bank to a requested word, verifies Q and retries a bounded number of times.
module jk_target_driver
  import jk_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MAX_RETRY  = 2,
  parameter int USE_TOGGLE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);
  localparam logic       TOGGLE_EN   = (USE_TOGGLE != 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [2:0]       retry_q, retry_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             done_q, done_d, err_q, err_d;

  logic [WIDTH-1:0] ex_t, ex_j, ex_k;

  // One excitation unit serves both the first drive (incoming word) and retries (latched word).
  assign ex_t = (state_q == ST_IDLE) ? tgt_data : tgt_q;

  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .q          (q_fb),
    .t          (ex_t),
    .use_toggle (TOGGLE_EN),
    .j          (ex_j),
    .k          (ex_k)
  );

  assign tgt_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;
  assign err       = err_q;

  // Next-state logic: J/K, done and err default to 0 so each is a one-cycle event.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    retry_d = retry_q;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tgt_valid) begin
          tgt_d   = tgt_data;
          retry_d = '0;
          j_d     = ex_j;
          k_d     = ex_k;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (q_fb == tgt_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (retry_q < RETRY_LIMIT) begin
          retry_d = retry_q + 3'd1;
          j_d     = ex_j;
          k_d     = ex_k;
          state_d = ST_DRIVE;
        end else begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, target latch, retry counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      retry_q <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make every register see pre-edge values, matching flop behaviour.
      state_q <= state_d;
      tgt_q   <= tgt_d;
      retry_q <= retry_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule
